dff_shift_reg: RTL and testbench
================================

// Module: dff_shift_reg
// PURPOSE
//  Parametrised edge-triggered register: WIDTH master-slave flip-flops built
//  from complementary-enable latch pairs, with async reset and a 4-way mode
//  mux (hold / parallel load / shift left / shift right).
//  Generalises the single-bit level-sensitive latch cell into a clocked,
//  resettable, multi-bit storage element.
//  Serves as a datapath register, shift register and serial/parallel converter
//  in the core.
//  Nets are named in the codebase's CLK / nCLK / nQ style.
// PARAMETERS
//  WIDTH      8     number of bits, >= 1
//  RESET_VAL  0     WIDTH-bit value forced onto Q while nRST is low
// PORTS
//  CLK      in   1      sole clock; rising-edge triggered
//  nRST     in   1      asynchronous, active-low reset
//  MODE     in   2      00 hold, 01 load D, 10 shift left, 11 shift right
//  D        in   WIDTH  parallel load data
//  SIN      in   1      serial input bit for both shift modes
//  Q        out  WIDTH  registered state
//  nQ       out  WIDTH  bitwise complement of Q, always ~Q
//  SOUT_L   out  1      Q[WIDTH-1] (bit shifted out by a left shift)
//  SOUT_R   out  1      Q[0] (bit shifted out by a right shift)
// BEHAVIOUR
//  Structure
//  - Per bit: master latch transparent while CLK=0, slave transparent while
//    CLK=1.
//  - nCLK is generated once internally as ~CLK; it is not a port.
//  - Net effect: Q updates only on the rising CLK edge.
//  - No level-transparent path from D or SIN to Q.
//  Reset
//  - nRST=0 immediately forces Q=RESET_VAL and nQ=~RESET_VAL, independent of CLK.
//  - The force is applied to both master and slave of every bit.
//  - nRST low overrides MODE.
//  - While nRST=0, rising edges do not change Q.
//  - First capture happens on the first rising edge with nRST=1.
//  - nRST rising coincident with a CLK rising edge is a setup violation.
//    The driver deasserts nRST while CLK=0.
//  Next state Q+ at a rising edge
//  - MODE=00: Q+ = Q
//  - MODE=01: Q+ = D
//  - MODE=10: Q+ = {Q[WIDTH-2:0], SIN}
//  - MODE=11: Q+ = {SIN, Q[WIDTH-1:1]}
//  - WIDTH=1: both shift modes give Q+ = SIN.
//  Timing
//  - Latency: one edge.
//  - MODE, D and SIN are sampled at the edge only.
//  - Changes between edges have no effect on Q.
//  Outputs
//  - SOUT_L and SOUT_R are combinational taps of Q.
//  - Both are valid from reset onward and update with Q.
//  - Chaining: SOUT_L of stage k drives SIN of stage k+1 (left); likewise
//    SOUT_R for right shifts.
//  Invariants
//  - nQ == ~Q at all times outside edge transitions.
//  - No X on Q after reset.
// TESTING
//  1. Reset (WIDTH=8, RESET_VAL=8'hA5):
//     - Drive D=8'hFF, MODE=01, nRST=0 across 3 edges -> Q=A5, nQ=5A throughout.
//     - Release nRST at CLK=0 -> Q=FF after the next edge.
//  2. Load/hold:
//     - MODE=01, D=3C -> Q=3C at the edge.
//     - MODE=00, D=C3 for 4 edges -> Q stays 3C.
//     - D toggled mid-cycle -> Q unchanged until the edge.
//  3. Shift left:
//     - From Q=81, MODE=10, SIN=0 -> Q=02 with SOUT_L=1 before the edge.
//     - Then SIN=1 -> Q=05.
//  4. Shift right:
//     - From Q=81, MODE=11, SIN=1 -> Q=C0.
//     - 8 further edges with SIN=0 -> Q=00; SOUT_R sequence 0,0,0,0,0,0,1,1.
//  5. Async reset mid-operation:
//     - Q=5A; pull nRST low while CLK=1 (between edges) -> Q=RESET_VAL
//       immediately, with no wait for an edge.
//  6. Edge cases:
//     - WIDTH=1, RESET_VAL=1: MODE=10, SIN=0 -> Q=0; MODE=11, SIN=1 -> Q=1.
//     - Check SOUT_L == SOUT_R == Q at every step.
//     - Check nQ == ~Q sampled every half-cycle in all tests.

Source files
------------

// File: rtl/dff_shift_reg.sv
// dff_shift_reg: WIDTH-bit rising-edge register with asynchronous active-low
// reset and a hold / parallel-load / shift-left / shift-right mode mux.
module dff_shift_reg #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SIN,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] nQ,
    output logic             SOUT_L,
    output logic             SOUT_R
);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_SHR  = 2'b11;

    logic [WIDTH-1:0] q_s;

    // Each bit behaves as a master latch open while CLK is low feeding a slave
    // open while CLK is high, so the stored value only moves on the rising edge.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic left_src_s;
        logic right_src_s;
        logic next_s;
        logic bit_r;

        // Neighbour taps; the end bits take SIN, and a 1-bit register takes SIN both ways.
        if (WIDTH == 1) begin : g_single
            assign left_src_s  = SIN;
            assign right_src_s = SIN;
        end else if (i == 0) begin : g_lsb
            assign left_src_s  = SIN;
            assign right_src_s = q_s[i+1];
        end else if (i == WIDTH - 1) begin : g_msb
            assign left_src_s  = q_s[i-1];
            assign right_src_s = SIN;
        end else begin : g_mid
            assign left_src_s  = q_s[i-1];
            assign right_src_s = q_s[i+1];
        end

        // Mode mux selecting this bit's next state.
        always_comb begin
            next_s = bit_r;
            case (MODE)
                MODE_HOLD: next_s = bit_r;
                MODE_LOAD: next_s = D[i];
                MODE_SHL:  next_s = left_src_s;
                MODE_SHR:  next_s = right_src_s;
                default:   next_s = bit_r;
            endcase
        end

        // Storage cell; reset forces the whole cell regardless of CLK or MODE.
        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                bit_r <= RESET_VAL[i];
            end else begin
                bit_r <= next_s;
            end
        end

        assign q_s[i] = bit_r;
    end

    assign Q      = q_s;
    assign nQ     = ~q_s;
    assign SOUT_L = q_s[WIDTH-1];
    assign SOUT_R = q_s[0];

endmodule

// File: tb/tb_dff_shift_reg.sv
// Self-checking bench for dff_shift_reg: an 8-bit instance (RESET_VAL=A5) and a
// 1-bit instance (RESET_VAL=1) checked against a behavioural model every half-cycle.
module tb_dff_shift_reg;

    logic       clk  = 1'b0;
    logic       nrst = 1'b1;
    logic [1:0] mode8 = 2'b01;
    logic [7:0] d8    = 8'hFF;
    logic       sin8  = 1'b0;
    logic [7:0] q8, nq8;
    logic       sl8, sr8;
    logic [1:0] mode1 = 2'b00;
    logic [0:0] d1    = 1'b0;
    logic       sin1  = 1'b0;
    logic [0:0] q1, nq1;
    logic       sl1, sr1;

    logic [7:0] m8;
    logic [7:0] m1;
    int checks = 0;
    int errors = 0;

    dff_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
        .CLK(clk), .nRST(nrst), .MODE(mode8), .D(d8), .SIN(sin8),
        .Q(q8), .nQ(nq8), .SOUT_L(sl8), .SOUT_R(sr8)
    );

    dff_shift_reg #(.WIDTH(1), .RESET_VAL(1'b1)) dut1 (
        .CLK(clk), .nRST(nrst), .MODE(mode1), .D(d1), .SIN(sin1),
        .Q(q1), .nQ(nq1), .SOUT_L(sl1), .SOUT_R(sr1)
    );

    always #5 clk = ~clk;

    // Next value of a w-bit register as plain arithmetic on an 8-bit container.
    function automatic logic [7:0] next_val(input int w, input logic [7:0] q,
                                            input logic [1:0] mode, input logic [7:0] d,
                                            input logic sin);
        logic [7:0] mask;
        mask = 8'hFF >> (8 - w);
        case (mode)
            2'd0:    return q & mask;
            2'd1:    return d & mask;
            2'd2:    return ((q << 1) | {7'b0, sin}) & mask;
            default: return ((q >> 1) | ({7'b0, sin} << (w - 1))) & mask;
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m8 <= 8'hA5;
            m1 <= 8'h01;
        end else begin
            m8 <= next_val(8, m8, mode8, d8, sin8);
            m1 <= next_val(1, m1, mode1, {7'b0, d1}, sin1);
        end
    end

    // Compare every half-cycle, away from the edge.
    always @(clk) begin
        #2;
        chk("q8",    q8,  m8);
        chk("nq8",   nq8, ~m8);
        chk("soutl8", {7'b0, sl8}, {7'b0, m8[7]});
        chk("soutr8", {7'b0, sr8}, {7'b0, m8[0]});
        chk("q1",    {7'b0, q1},  {7'b0, m1[0]});
        chk("nq1",   {7'b0, nq1}, {7'b0, ~m1[0]});
        chk("soutl1", {7'b0, sl1}, {7'b0, m1[0]});
        chk("soutr1", {7'b0, sr1}, {7'b0, m1[0]});
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] sr_seq;
        sr_seq = 8'b1100_0000;

        // Reset held across edges while loading FF is requested.
        #1 nrst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_q", q8, 8'hA5);
            chk("rst_nq", nq8, 8'h5A);
        end
        nrst = 1'b1;
        step();
        chk("first_load", q8, 8'hFF);

        // Load then hold.
        d8 = 8'h3C;
        step();
        chk("load_3c", q8, 8'h3C);
        mode8 = 2'b00;
        d8 = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hold_3c", q8, 8'h3C);
        end

        // Data changes between edges must not reach Q.
        mode8 = 2'b01;
        d8 = 8'h5F;
        @(posedge clk);
        #3 d8 = 8'hE0;
        #1 chk("mid_hi", q8, 8'h5F);
        @(negedge clk);
        #3 d8 = 8'h0F;
        #1 chk("mid_lo", q8, 8'h5F);
        step();
        chk("after_mid", q8, 8'h0F);

        // Shift left.
        d8 = 8'h81;
        step();
        mode8 = 2'b10;
        sin8 = 1'b0;
        #1 chk("soutl_pre", {7'b0, sl8}, 8'h01);
        step();
        chk("shl_02", q8, 8'h02);
        sin8 = 1'b1;
        step();
        chk("shl_05", q8, 8'h05);

        // Shift right.
        mode8 = 2'b01;
        d8 = 8'h81;
        step();
        mode8 = 2'b11;
        sin8 = 1'b1;
        step();
        chk("shr_c0", q8, 8'hC0);
        sin8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("soutr_seq", {7'b0, sr8}, {7'b0, sr_seq[i]});
            step();
        end
        chk("shr_00", q8, 8'h00);

        // Asynchronous reset between edges.
        mode8 = 2'b01;
        d8 = 8'h5A;
        step();
        chk("pre_rst", q8, 8'h5A);
        mode8 = 2'b00;
        @(posedge clk);
        #3 nrst = 1'b0;
        #1 chk("async_rst", q8, 8'hA5);
        chk("async_rst_nq", nq8, 8'h5A);
        @(negedge clk);
        #1 nrst = 1'b1;
        step();
        chk("post_rst_hold", q8, 8'hA5);

        // One-bit register.
        chk("w1_rst", {7'b0, q1}, 8'h01);
        mode1 = 2'b10;
        sin1 = 1'b0;
        step();
        chk("w1_shl", {7'b0, q1}, 8'h00);
        mode1 = 2'b11;
        sin1 = 1'b1;
        step();
        chk("w1_shr", {7'b0, q1}, 8'h01);
        mode1 = 2'b01;
        d1 = 1'b0;
        step();
        chk("w1_load", {7'b0, q1}, 8'h00);
        mode1 = 2'b10;
        sin1 = 1'b1;
        step();
        chk("w1_shl1", {7'b0, q1}, 8'h01);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
